jump_branch_sequencer: RTL and testbench
========================================

// Module: jump_branch_sequencer
// PURPOSE
//  Hardwired control sequencer for instruction fetch and control-transfer execute (jr, jal, branch).
//  It replaces bench-driven control signals: it steps T-states and drives the Datapath2 control inputs.
//  It adds memory wait states, the jal link path, conditional branch via CON FF, and a start/busy/done handshake.
// PARAMETERS
//  DATA_WIDTH  32      IR width; opcode is ir[DATA_WIDTH-1 -: 5]
//  MEM_WAIT    0       extra T1 cycles for memory read (0..15)
//  OP_BR       5'd18   branch opcode
//  OP_JAL      5'd19   jump-and-link opcode
//  OP_JR       5'd20   jump-register opcode
//  ALU_INC     5'd12   ALU code for PC+1
//  ALU_ADD     5'd3    ALU code for add
// PORTS
//  clk         in   1           clock, rising edge
//  clr         in   1           asynchronous active-high reset
//  start       in   1           begin one fetch+execute; sampled only in IDLE
//  ir          in   DATA_WIDTH  IR contents from datapath (valid from T3)
//  con_ff      in   1           CON FF output from datapath
//  PCout,Zlowout,MDRout,Cout,Rout,BAout  out 1  bus-drive enables
//  MARin,Zin,PCin,MDRin,IRin,Yin,Rin,CONin out 1 register load enables
//  Read        out  1           memory read strobe
//  Gra,Grb,Grc out  1           register-field selects
//  alu_op      out  5           ALU opcode to datapath
//  busy        out  1           high in every state except IDLE
//  done        out  1           one-cycle pulse at end of instruction
//  illegal     out  1           with done: opcode not BR/JAL/JR
//  tstate      out  4           current state code (debug)
// BEHAVIOUR
//  Moore machine: all outputs decode the state register; a state's signals hold for its entire cycle.
//  Reset (clr=1, any time, async): state=IDLE, wait counter=0, and all outputs 0, incl. alu_op, done, illegal.
//  A reset mid-instruction abandons it; no partial completion and no done.
//  States/codes: IDLE0 T0 1 T1 2 T2 3 T3 4 T4 5 T5 6 T6 7 DONE 8.
//  IDLE: all outputs 0; start=1 -> T0. start in any other state is ignored.
//  T0: PCout MARin Zin, alu_op=ALU_INC -> T1.
//  T1: Zlowout PCin asserted only in the first T1 cycle. Read held for 1+MEM_WAIT cycles.
//      MDRin asserts on the last T1 cycle only. The wait counter counts 0..MEM_WAIT, then -> T2.
//  T2: MDRout IRin -> T3.
//  T3 decode on op=ir[DATA_WIDTH-1 -: 5]:
//   OP_JR : Gra Rout PCin -> DONE
//   OP_JAL: PCout Grb Rin (link = PC+1 into Rb) -> T4; T4: Gra Rout PCin -> DONE
//   OP_BR : Gra Rout CONin -> T4; T4: PCout Yin -> T5; T5: Cout Zin, alu_op=ALU_ADD -> T6
//           T6: Zlowout, PCin = con_ff (sampled combinationally in T6) -> DONE
//   other : no control signals -> DONE, illegal=1
//  DONE: done=1 for one cycle; illegal held from decode; busy=1 -> IDLE. start in DONE is ignored.
//  alu_op is 0 outside T0/T5. At most one bus driver is active per cycle (PCout/Zlowout/MDRout/Rout/Cout exclusive).
//  Latency (start edge to done): jr 5+MEM_WAIT, jal 6+MEM_WAIT, br 8+MEM_WAIT cycles.
// TESTING
//  jr, MEM_WAIT=0, ir=32'hA1000000, start pulse -> T0..T3 one cycle each, T3 has Gra&Rout&PCin, done at 5th cycle after start.
//  jr, MEM_WAIT=2 -> Read high 3 cycles; MDRin only in 3rd; Zlowout/PCin only in 1st; done at 7th cycle.
//  br (op 18), con_ff=1 -> T5 alu_op=3 with Cout&Zin, T6 PCin=1; repeat with con_ff=0 -> T6 PCin=0, done still pulses.
//  jal (op 19) -> T3 PCout&Grb&Rin, T4 Gra&Rout&PCin, then done; no bus-driver overlap in any cycle.
//  ir opcode 5'd31 -> done with illegal=1, and no load enables asserted in T3; start while busy -> no restart.
//  clr asserted asynchronously during br T5 -> outputs 0 immediately, tstate=0, no done; next start runs a normal fetch.

Source files
------------

// File: rtl/jump_branch_sequencer.sv
// -----------------------------------------------------------------------------
// jump_branch_sequencer
//
// Hardwired control sequencer for instruction fetch and the control-transfer
// instructions jr, jal and conditional branch. It steps through T-states and
// drives the Datapath2 control inputs. The fetch includes optional memory wait
// states, and a start/busy/done handshake frames each instruction.
//
// Every output is decoded from the state register (Moore style), so a state's
// signals hold for its whole cycle. The one exception is PCin in T6, which
// follows con_ff within that cycle.
//
// Ports
//   clk          in   1            clock, rising edge
//   clr          in   1            asynchronous active-high reset
//   start        in   1            begin one fetch+execute, sampled only in IDLE
//   ir           in   DATA_WIDTH   instruction register contents (valid from T3)
//   con_ff       in   1            CON flip-flop output from the datapath
//   PCout, Zlowout, MDRout, Cout, Rout, BAout    out  bus-drive enables
//   MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin out register load enables
//   Read         out  1            memory read strobe
//   Gra, Grb, Grc out 1            register-field selects
//   alu_op       out  5            ALU opcode to the datapath
//   busy         out  1            high in every state except IDLE
//   done         out  1            one-cycle pulse at the end of an instruction
//   illegal      out  1            valid with done: opcode was not BR/JAL/JR
//   tstate       out  4            current state code (debug)
// -----------------------------------------------------------------------------
module jump_branch_sequencer #(
    parameter int         DATA_WIDTH = 32,
    parameter int         MEM_WAIT   = 0,
    parameter logic [4:0] OP_BR      = 5'd18,
    parameter logic [4:0] OP_JAL     = 5'd19,
    parameter logic [4:0] OP_JR      = 5'd20,
    parameter logic [4:0] ALU_INC    = 5'd12,
    parameter logic [4:0] ALU_ADD    = 5'd3
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic                  con_ff,
    output logic                  PCout,
    output logic                  Zlowout,
    output logic                  MDRout,
    output logic                  Cout,
    output logic                  Rout,
    output logic                  BAout,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Rin,
    output logic                  CONin,
    output logic                  Read,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Grc,
    output logic [4:0]            alu_op,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [3:0]            tstate
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    // Value of the wait counter in the final T1 cycle (the memory data is ready).
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       is_br_q, is_br_d;
    logic [4:0] opcode_s;
    logic       unused_ir_s;

    // True when the opcode is one of the control-transfer instructions handled here.
    function automatic logic op_is_legal(input logic [4:0] op);
        return (op == OP_BR) || (op == OP_JAL) || (op == OP_JR);
    endfunction

    assign opcode_s    = ir[DATA_WIDTH-1 -: 5];
    assign unused_ir_s = ^ir[DATA_WIDTH-6:0];
    assign tstate      = state_q;

    // State, wait counter and decode-time flags; clr abandons any instruction.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
            is_br_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            is_br_q   <= is_br_d;
        end
    end

    // Next-state logic, wait counting and capture of decode results.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        is_br_d   = is_br_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_T0;
                    wait_d    = 4'd0;
                    illegal_d = 1'b0;
                    is_br_d   = 1'b0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_T0: begin
                state_d = S_T1;
                wait_d  = 4'd0;
            end
            S_T1: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_T2;
                    wait_d  = 4'd0;
                end else begin
                    wait_d  = wait_q + 4'd1;
                end
            end
            S_T2: begin
                state_d = S_T3;
            end
            S_T3: begin
                // The instruction type is latched here so later states do not
                // depend on ir staying stable.
                is_br_d   = (opcode_s == OP_BR);
                illegal_d = !op_is_legal(opcode_s);
                if ((opcode_s == OP_JAL) || (opcode_s == OP_BR)) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_T4: begin
                if (is_br_q) begin
                    state_d = S_T5;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_T5: begin
                state_d = S_T6;
            end
            S_T6: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                wait_d    = 4'd0;
                illegal_d = 1'b0;
                is_br_d   = 1'b0;
            end
        endcase
    end

    // Control-signal decode. Each state drives at most one bus source.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Rin     = 1'b0;
        CONin   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        alu_op  = 5'd0;
        busy    = 1'b1;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                Zin    = 1'b1;
                alu_op = ALU_INC;
            end
            S_T1: begin
                Read = 1'b1;
                // PC+1 is written back only once, however long the read stalls.
                if (wait_q == 4'd0) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end else begin
                    Zlowout = 1'b0;
                    PCin    = 1'b0;
                end
                if (wait_q == WAIT_LAST) begin
                    MDRin = 1'b1;
                end else begin
                    MDRin = 1'b0;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (opcode_s)
                    OP_JR: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        PCin = 1'b1;
                    end
                    OP_JAL: begin
                        // Link: the already-incremented PC goes into Rb.
                        PCout = 1'b1;
                        Grb   = 1'b1;
                        Rin   = 1'b1;
                    end
                    OP_BR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        CONin = 1'b1;
                    end
                    default: begin
                        Gra = 1'b0;
                    end
                endcase
            end
            S_T4: begin
                if (is_br_q) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end
            end
            S_T5: begin
                Cout   = 1'b1;
                Zin    = 1'b1;
                alu_op = ALU_ADD;
            end
            S_T6: begin
                // The branch target is loaded only when the condition holds.
                Zlowout = 1'b1;
                PCin    = con_ff;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jump_branch_sequencer.sv
module tb_jump_branch_sequencer;

    // Bit positions inside the packed control vectors c0/c2
    localparam logic [20:0] B_PCOUT = 21'd1 << 0;
    localparam logic [20:0] B_ZLO   = 21'd1 << 1;
    localparam logic [20:0] B_MDRO  = 21'd1 << 2;
    localparam logic [20:0] B_COUT  = 21'd1 << 3;
    localparam logic [20:0] B_ROUT  = 21'd1 << 4;
    localparam logic [20:0] B_MARI  = 21'd1 << 6;
    localparam logic [20:0] B_ZI    = 21'd1 << 7;
    localparam logic [20:0] B_PCI   = 21'd1 << 8;
    localparam logic [20:0] B_MDRI  = 21'd1 << 9;
    localparam logic [20:0] B_IRI   = 21'd1 << 10;
    localparam logic [20:0] B_YI    = 21'd1 << 11;
    localparam logic [20:0] B_RI    = 21'd1 << 12;
    localparam logic [20:0] B_CONI  = 21'd1 << 13;
    localparam logic [20:0] B_RD    = 21'd1 << 14;
    localparam logic [20:0] B_GRA   = 21'd1 << 15;
    localparam logic [20:0] B_GRB   = 21'd1 << 16;
    localparam logic [20:0] B_BSY   = 21'd1 << 18;
    localparam logic [20:0] B_DN    = 21'd1 << 19;
    localparam logic [20:0] B_ILL   = 21'd1 << 20;
    localparam logic [20:0] DRIVERS = 21'h00003F;

    localparam logic [20:0] E_T0    = B_PCOUT | B_MARI | B_ZI | B_BSY;
    localparam logic [20:0] E_T1    = B_ZLO | B_PCI | B_RD | B_MDRI | B_BSY;
    localparam logic [20:0] E_T1F   = B_ZLO | B_PCI | B_RD | B_BSY;
    localparam logic [20:0] E_T1M   = B_RD | B_BSY;
    localparam logic [20:0] E_T1L   = B_RD | B_MDRI | B_BSY;
    localparam logic [20:0] E_T2    = B_MDRO | B_IRI | B_BSY;
    localparam logic [20:0] E_JR3   = B_GRA | B_ROUT | B_PCI | B_BSY;
    localparam logic [20:0] E_JAL3  = B_PCOUT | B_GRB | B_RI | B_BSY;
    localparam logic [20:0] E_BR3   = B_GRA | B_ROUT | B_CONI | B_BSY;
    localparam logic [20:0] E_BR4   = B_PCOUT | B_YI | B_BSY;
    localparam logic [20:0] E_BR5   = B_COUT | B_ZI | B_BSY;
    localparam logic [20:0] E_BR61  = B_ZLO | B_PCI | B_BSY;
    localparam logic [20:0] E_BR60  = B_ZLO | B_BSY;
    localparam logic [20:0] E_DONE  = B_DN | B_BSY;
    localparam logic [20:0] E_ILLD  = B_DN | B_BSY | B_ILL;
    localparam logic [20:0] E_IDLE  = 21'd0;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic        con_ff;

    logic [20:0] c0, c2;
    logic [4:0]  a0, a2;
    logic [3:0]  t0, t2;

    logic [20:0] cap0 [16];
    logic [20:0] cap2 [16];
    logic [4:0]  alu0 [16];
    logic [3:0]  ts0  [16];
    logic [3:0]  ts2  [16];

    int total;
    int bad;

    jump_branch_sequencer #(.DATA_WIDTH(32), .MEM_WAIT(0)) u_dut0 (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .con_ff(con_ff),
        .PCout(c0[0]), .Zlowout(c0[1]), .MDRout(c0[2]), .Cout(c0[3]), .Rout(c0[4]), .BAout(c0[5]),
        .MARin(c0[6]), .Zin(c0[7]), .PCin(c0[8]), .MDRin(c0[9]), .IRin(c0[10]), .Yin(c0[11]),
        .Rin(c0[12]), .CONin(c0[13]), .Read(c0[14]), .Gra(c0[15]), .Grb(c0[16]), .Grc(c0[17]),
        .alu_op(a0), .busy(c0[18]), .done(c0[19]), .illegal(c0[20]), .tstate(t0)
    );

    jump_branch_sequencer #(.DATA_WIDTH(32), .MEM_WAIT(2)) u_dut2 (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .con_ff(con_ff),
        .PCout(c2[0]), .Zlowout(c2[1]), .MDRout(c2[2]), .Cout(c2[3]), .Rout(c2[4]), .BAout(c2[5]),
        .MARin(c2[6]), .Zin(c2[7]), .PCin(c2[8]), .MDRin(c2[9]), .IRin(c2[10]), .Yin(c2[11]),
        .Rin(c2[12]), .CONin(c2[13]), .Read(c2[14]), .Gra(c2[15]), .Grb(c2[16]), .Grc(c2[17]),
        .alu_op(a2), .busy(c2[18]), .done(c2[19]), .illegal(c2[20]), .tstate(t2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start, then record both instances at each following falling edge.
    // restart_mask[k] drives start after sample k (to poke a busy sequencer).
    task automatic run_capture(input int ncyc, input logic [15:0] restart_mask);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            cap0[k] = c0;
            cap2[k] = c2;
            alu0[k] = a0;
            ts0[k]  = t0;
            ts2[k]  = t2;
            start   = restart_mask[k];
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; ir = 32'd0; con_ff = 1'b0;
        #12;
        total++; if (c0 !== 21'd0) begin bad++; $display("FAIL reset_ctl0 got=%h exp=%h", c0, 21'd0); end
        total++; if (c2 !== 21'd0) begin bad++; $display("FAIL reset_ctl2 got=%h exp=%h", c2, 21'd0); end
        total++; if (a0 !== 5'd0) begin bad++; $display("FAIL reset_alu got=%0d exp=0", a0); end
        total++; if (t0 !== 4'd0) begin bad++; $display("FAIL reset_tstate got=%0d exp=0", t0); end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_jr();
        logic [20:0] e0 [9];
        logic [20:0] e2 [9];
        logic [3:0]  s0 [9];
        logic [3:0]  s2 [9];
        e0 = '{E_T0, E_T1, E_T2, E_JR3, E_DONE, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
        e2 = '{E_T0, E_T1F, E_T1M, E_T1L, E_T2, E_JR3, E_DONE, E_IDLE, E_IDLE};
        s0 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
        s2 = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd8, 4'd0, 4'd0};
        ir = 32'hA100_0000;
        run_capture(9, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            total++; if (cap0[k] !== e0[k]) begin bad++; $display("FAIL jr_w0_ctl c%0d got=%h exp=%h", k, cap0[k], e0[k]); end
            total++; if (ts0[k] !== s0[k]) begin bad++; $display("FAIL jr_w0_tstate c%0d got=%0d exp=%0d", k, ts0[k], s0[k]); end
            total++; if (cap2[k] !== e2[k]) begin bad++; $display("FAIL jr_w2_ctl c%0d got=%h exp=%h", k, cap2[k], e2[k]); end
            total++; if (ts2[k] !== s2[k]) begin bad++; $display("FAIL jr_w2_tstate c%0d got=%0d exp=%0d", k, ts2[k], s2[k]); end
        end
        total++; if (alu0[0] !== 5'd12) begin bad++; $display("FAIL jr_t0_alu got=%0d exp=12", alu0[0]); end
        total++; if (alu0[1] !== 5'd0) begin bad++; $display("FAIL jr_t1_alu got=%0d exp=0", alu0[1]); end
    endtask

    task automatic test_branch(input logic cond);
        logic [20:0] e0 [11];
        logic [4:0]  ea [11];
        e0 = '{E_T0, E_T1, E_T2, E_BR3, E_BR4, E_BR5, (cond ? E_BR61 : E_BR60), E_DONE, E_IDLE, E_IDLE, E_IDLE};
        ea = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        ir = 32'h9000_0000;
        con_ff = cond;
        run_capture(11, 16'h0000);
        for (int k = 0; k < 11; k++) begin
            total++; if (cap0[k] !== e0[k]) begin bad++; $display("FAIL br%0d_ctl c%0d got=%h exp=%h", cond, k, cap0[k], e0[k]); end
            total++; if (alu0[k] !== ea[k]) begin bad++; $display("FAIL br%0d_alu c%0d got=%0d exp=%0d", cond, k, alu0[k], ea[k]); end
        end
        total++; if (cap2[9] !== E_DONE) begin bad++; $display("FAIL br%0d_w2_done got=%h exp=%h", cond, cap2[9], E_DONE); end
        total++; if (cap2[8] !== (cond ? E_BR61 : E_BR60)) begin bad++; $display("FAIL br%0d_w2_t6 got=%h", cond, cap2[8]); end
        con_ff = 1'b0;
    endtask

    task automatic test_jal();
        logic [20:0] e0 [9];
        e0 = '{E_T0, E_T1, E_T2, E_JAL3, E_JR3, E_DONE, E_IDLE, E_IDLE, E_IDLE};
        ir = 32'h9800_0000;
        run_capture(9, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            total++; if (cap0[k] !== e0[k]) begin bad++; $display("FAIL jal_ctl c%0d got=%h exp=%h", k, cap0[k], e0[k]); end
            total++; if ($countones(cap0[k] & DRIVERS) > 1) begin bad++; $display("FAIL jal_bus_w0 c%0d got=%h exp=one-hot", k, cap0[k] & DRIVERS); end
            total++; if ($countones(cap2[k] & DRIVERS) > 1) begin bad++; $display("FAIL jal_bus_w2 c%0d got=%h exp=one-hot", k, cap2[k] & DRIVERS); end
        end
        total++; if (cap2[7] !== E_DONE) begin bad++; $display("FAIL jal_w2_done got=%h exp=%h", cap2[7], E_DONE); end
    endtask

    task automatic test_illegal_and_busy_start();
        logic [20:0] e0 [9];
        logic [3:0]  s0 [9];
        e0 = '{E_T0, E_T1, E_T2, E_IDLE | B_BSY, E_ILLD, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
        s0 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
        ir = 32'hF800_0000;
        run_capture(9, 16'h0012);
        for (int k = 0; k < 9; k++) begin
            total++; if (cap0[k] !== e0[k]) begin bad++; $display("FAIL ill_ctl c%0d got=%h exp=%h", k, cap0[k], e0[k]); end
            total++; if (ts0[k] !== s0[k]) begin bad++; $display("FAIL ill_tstate c%0d got=%0d exp=%0d", k, ts0[k], s0[k]); end
        end
        total++; if (cap2[6] !== E_ILLD) begin bad++; $display("FAIL ill_w2_done got=%h exp=%h", cap2[6], E_ILLD); end
        total++; if (ts2[7] !== 4'd0) begin bad++; $display("FAIL ill_w2_idle got=%0d exp=0", ts2[7]); end
    endtask

    task automatic test_clr_mid_branch();
        logic found;
        found = 1'b0;
        ir = 32'h9000_0000;
        con_ff = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (t0 == 4'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL clr_reach_t5 got=%0d exp=1", found); end
        #2 clr = 1'b1;
        #1;
        total++; if (c0 !== 21'd0) begin bad++; $display("FAIL clr_async_ctl got=%h exp=0", c0); end
        total++; if (a0 !== 5'd0) begin bad++; $display("FAIL clr_async_alu got=%0d exp=0", a0); end
        total++; if (t0 !== 4'd0) begin bad++; $display("FAIL clr_async_tstate got=%0d exp=0", t0); end
        @(negedge clk);
        clr = 1'b0;
        con_ff = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if ((c0[19] !== 1'b0) || (t0 !== 4'd0)) begin bad++; $display("FAIL clr_no_done c%0d got=%b/%0d exp=0/0", k, c0[19], t0); end
        end
        ir = 32'hA100_0000;
        run_capture(9, 16'h0000);
        total++; if (cap0[0] !== E_T0) begin bad++; $display("FAIL clr_refetch_t0 got=%h exp=%h", cap0[0], E_T0); end
        total++; if (cap0[1] !== E_T1) begin bad++; $display("FAIL clr_refetch_t1 got=%h exp=%h", cap0[1], E_T1); end
        total++; if (cap0[4] !== E_DONE) begin bad++; $display("FAIL clr_refetch_done got=%h exp=%h", cap0[4], E_DONE); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_jr();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jal();
        test_illegal_and_busy_start();
        test_clr_mid_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
